pc_unit: RTL and testbench

Parametrised program-counter unit for the IF stage: holds the fetch PC, generates the sequential next PC internally, and applies branch/jump redirects with fixed priority. It also handles pipeline stalls and provides run/single-step/halt control for the debug unit. It replaces the bare PC register plus external next-PC mux, and feeds the instruction-memory address and the PC+INC link value to downstream stages.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_ctrl_fsm.sv | 51 +++++
 rtl/pc_unit.sv | 97 +++++++++
 tb/tb_pc_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
package pc_pkg;

  localparam int unsigned PC_NB_DEFAULT  = 32;
  localparam int unsigned PC_INC_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_fsm.sv
// Run/step/halt control FSM for the program-counter unit.
// Decides when the PC register may update and when fetch stops for good.
module pc_ctrl_fsm
  import pc_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_enable,
  input  logic      i_step,
  input  logic      i_advance,   // sequential advance possible (no stall)
  input  logic      i_halt,      // raw halt decode, outranked by redirects
  input  logic      i_misalign,  // winning redirect target is misaligned
  input  logic      i_redirect,  // branch or jump present this cycle
  output pc_state_t o_state,
  output logic      o_update_en
);

  pc_state_t state;
  logic      stop;

  // A halt only counts when no older redirect discards it.
  assign stop = i_misalign | (i_halt & ~i_redirect);

  // State register and transitions; HALTED is left only through reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable)    state <= RUN;
          else if (i_step) state <= STEP;
        end
        RUN: begin
          if (stop)           state <= HALTED;
          else if (!i_enable) state <= IDLE;
        end
        STEP: begin
          if (stop)                        state <= HALTED;
          else if (i_redirect || i_advance) state <= IDLE;
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_state     = state;
  assign o_update_en = (state == RUN) || (state == STEP);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: fetch PC register, sequential
// incrementer, branch/jump redirect priority mux and debug run control.
// Optional build macro PC_ALIGN_CHECK_EN enables the redirect alignment check.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      NB_PC    = PC_NB_DEFAULT,
  parameter int unsigned      PC_INC   = PC_INC_DEFAULT,
  parameter logic [NB_PC-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [NB_PC-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [NB_PC-1:0] i_jump_target,
  input  logic             i_halt,
  output logic [NB_PC-1:0] o_pc,
  output logic [NB_PC-1:0] o_pc_next,
  output logic             o_fetch_valid,
  output logic [1:0]       o_state,
  output logic             o_misaligned
);

  localparam logic [NB_PC-1:0] INC = NB_PC'(PC_INC);

  logic [NB_PC-1:0] pc_q;
  logic [NB_PC-1:0] pc_d;
  logic [NB_PC-1:0] redirect_target;
  logic             redirect;
  logic             misalign;
  logic             update_en;
  pc_state_t        state;

  // Branch resolves in EX and is older than a jump in ID, so it wins.
  assign redirect        = i_branch_taken | i_jump;
  assign redirect_target = i_branch_taken ? i_branch_target : i_jump_target;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [NB_PC-1:0] ALIGN_MASK = NB_PC'(PC_INC - 1);

  logic misaligned_q;

  assign misalign = redirect && ((redirect_target & ALIGN_MASK) != '0);

  // Sticky misalignment flag, set only when the PC could have updated.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                    misaligned_q <= 1'b0;
    else if (update_en && misalign) misaligned_q <= 1'b1;
  end

  assign o_misaligned = misaligned_q;
`else
  assign misalign     = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  pc_ctrl_fsm u_ctrl (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_step      (i_step),
    .i_advance   (~i_stall),
    .i_halt      (i_halt),
    .i_misalign  (misalign),
    .i_redirect  (redirect),
    .o_state     (state),
    .o_update_en (update_en)
  );

  // Next-PC priority: redirect (ignores stall), halt hold, sequential, hold.
  always_comb begin
    pc_d = pc_q;
    if (update_en) begin
      if (redirect) begin
        if (!misalign) pc_d = redirect_target;
      end else if (!i_halt && !i_stall) begin
        pc_d = pc_q + INC;
      end
    end
  end

  // Fetch PC register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign o_pc          = pc_q;
  assign o_pc_next     = pc_q + INC;
  assign o_state       = state;
  assign o_fetch_valid = (state == RUN) || (state == STEP);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// stimulus compared against a behavioural model of the fetch PC rules.
module tb_pc_unit;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int unsigned INC    = 4;

  logic        clk = 1'b0;
  logic        rst, en, step, stall, br, jmp, halt;
  logic [31:0] br_t, jmp_t;
  logic [31:0] pc, pc_next;
  logic        fv, mis;
  logic [1:0]  st;

  int tests = 0;
  int fails = 0;

  // Model state: 0 idle, 1 run, 2 step, 3 halted.
  logic [31:0] m_pc;
  int          m_state;
  bit          m_mis;

  always #5 clk = ~clk;

  pc_unit #(
    .NB_PC    (32),
    .PC_INC   (INC),
    .RESET_PC (RST_PC)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_step          (step),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (br_t),
    .i_jump          (jmp),
    .i_jump_target   (jmp_t),
    .i_halt          (halt),
    .o_pc            (pc),
    .o_pc_next       (pc_next),
    .o_fetch_valid   (fv),
    .o_state         (st),
    .o_misaligned    (mis)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_state = 0;
    m_mis   = 0;
  endtask

  // One clock edge of the fetch rules, using the inputs applied before it.
  task automatic model_clock();
    bit          redirect;
    bit          bad;
    logic [31:0] tgt;
    redirect = br || jmp;
    tgt      = br ? br_t : jmp_t;
    bad      = 0;
    case (m_state)
      0: begin
        if (en)        m_state = 1;
        else if (step) m_state = 2;
      end
      1, 2: begin
`ifdef PC_ALIGN_CHECK_EN
        if (redirect && (tgt % INC) != 0) bad = 1;
`endif
        if (bad) begin
          m_mis   = 1;
          m_state = 3;
        end else if (redirect) begin
          m_pc    = tgt;
          m_state = (m_state == 1 && en) ? 1 : 0;
        end else if (halt) begin
          m_state = 3;
        end else if (!stall) begin
          m_pc    = m_pc + INC;
          m_state = (m_state == 1 && en) ? 1 : 0;
        end else begin
          if (m_state == 1 && !en) m_state = 0;
        end
      end
      default: m_state = 3;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      pc,      m_pc);
    chk({tag, ".pc_next"}, pc_next, m_pc + INC);
    chk({tag, ".state"},   32'(st), 32'(m_state));
    chk({tag, ".fv"},      32'(fv), (m_state == 1 || m_state == 2) ? 32'd1 : 32'd0);
    chk({tag, ".mis"},     32'(mis), 32'(m_mis));
  endtask

  task automatic cyc(input logic a_en, input logic a_step, input logic a_stall,
                     input logic a_br, input logic [31:0] a_bt,
                     input logic a_jmp, input logic [31:0] a_jt,
                     input logic a_halt, input string tag);
    en = a_en; step = a_step; stall = a_stall;
    br = a_br; br_t = a_bt; jmp = a_jmp; jmp_t = a_jt; halt = a_halt;
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int halted_cycles;
    rst = 1'b0; en = 1'b0; step = 1'b0; stall = 1'b0;
    br = 1'b0; jmp = 1'b0; halt = 1'b0; br_t = '0; jmp_t = '0;
    model_reset();
    #2;
    do_reset();
    chk("rst.pc_const", pc, 32'h100);
    chk("rst.next_const", pc_next, 32'h104);

    // Enable for four cycles.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "en1"); chk("en1.pc_const", pc, 32'h100);
    chk("en1.fv_const", 32'(fv), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "en2"); chk("en2.pc_const", pc, 32'h104);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "en3"); chk("en3.pc_const", pc, 32'h108);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "en4"); chk("en4.pc_const", pc, 32'h10C);

    // Redirect overrides stall; stall alone holds.
    cyc(1, 0, 0, 1, 32'h200, 0, 0, 0, "br200");
    cyc(1, 0, 1, 1, 32'h400, 0, 0, 0, "brstall"); chk("brstall.pc_const", pc, 32'h400);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, "stall"); chk("stall.pc_const", pc, 32'h400);

    // Branch beats jump and halt.
    cyc(1, 0, 0, 1, 32'h500, 1, 32'h300, 1, "prio");
    chk("prio.pc_const", pc, 32'h500);
    chk("prio.st_const", 32'(st), 32'd1);

    // Wrap to zero.
    cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, "brtop");
    chk("brtop.next_const", pc_next, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "wrap"); chk("wrap.pc_const", pc, 32'h0);

    // Halt is terminal.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, "halt");
    chk("halt.st_const", 32'(st), 32'd3);
    chk("halt.fv_const", 32'(fv), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "halted1");
    cyc(1, 1, 0, 1, 32'h800, 0, 0, 0, "halted2");
    chk("halted2.st_const", 32'(st), 32'd3);

    // Single step with two stalled cycles.
    do_reset();
    cyc(0, 1, 1, 0, 0, 0, 0, 0, "step0"); chk("step0.st_const", 32'(st), 32'd2);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "step1"); chk("step1.st_const", 32'(st), 32'd2);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "step2"); chk("step2.pc_const", pc, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "step3"); chk("step3.pc_const", pc, 32'h104);
    chk("step3.st_const", 32'(st), 32'd0);

    // Misaligned branch target.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "mis_en");
    cyc(1, 0, 0, 1, 32'h402, 0, 0, 0, "mis_br");
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_br.pc_const", pc, 32'h100);
    chk("mis_br.flag_const", 32'(mis), 32'd1);
    chk("mis_br.st_const", 32'(st), 32'd3);
`else
    chk("mis_br.pc_const", pc, 32'h402);
    chk("mis_br.flag_const", 32'(mis), 32'd0);
    chk("mis_br.st_const", 32'(st), 32'd1);
`endif

    // Losing jump target is not checked.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "lose_en");
    cyc(1, 0, 0, 1, 32'h600, 1, 32'h301, 0, "lose");
    chk("lose.pc_const", pc, 32'h600);
    chk("lose.flag_const", 32'(mis), 32'd0);

    // Random stimulus against the model.
    do_reset();
    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 3) halted_cycles++;
      if (halted_cycles > 4 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halted_cycles = 0;
      end else begin
        logic [31:0] bt;
        logic [31:0] jt;
        bt = $urandom & ~32'h3;
        jt = $urandom & ~32'h3;
        if ($urandom_range(0, 7) == 0) bt = $urandom;
        if ($urandom_range(0, 7) == 0) jt = $urandom;
        cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, bt,
            $urandom_range(0, 7) == 0, jt, $urandom_range(0, 39) == 0, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
